// File: rtl/bist_engine_if.sv
// Signal bundle between the BIST engine, its test controller and the SRAM macro.
interface bist_engine_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 4;

  logic [3:0]    select;
  logic [DW-1:0] dat_in;
  logic [DW-1:0] dat_out;
  logic [AW-1:0] addr_out;
  logic          w_en;
  logic          op_done;
  logic          fail;

  modport master (
    input  select,
    input  dat_in,
    output dat_out,
    output addr_out,
    output w_en,
    output op_done,
    output fail
  );

  modport slave (
    output select,
    output dat_in,
    input  dat_out,
    input  addr_out,
    input  w_en,
    input  op_done,
    input  fail
  );
endinterface

// File: rtl/bist_engine.sv
// March-style BIST engine for a 256 x 4 single-port SRAM: six selectable
// algorithms, one memory operation per cycle, sticky miscompare flag.
module bist_engine (
  input  logic          clk,
  input  logic          rst_n,
  bist_engine_if.master bus
);
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned EW = 3;
  localparam int unsigned OW = 2;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Op code {write, data}; data: 0 = zeros, 1 = ones, 2 = P, 3 = ~P
  localparam logic [2:0] R0 = 3'b000;
  localparam logic [2:0] R1 = 3'b001;
  localparam logic [2:0] RP = 3'b010;
  localparam logic [2:0] RN = 3'b011;
  localparam logic [2:0] W0 = 3'b100;
  localparam logic [2:0] W1 = 3'b101;
  localparam logic [2:0] WP = 3'b110;
  localparam logic [2:0] WN = 3'b111;

  typedef struct packed {
    logic          down;
    logic [OW-1:0] nops;
    logic [2:0]    op0;
    logic [2:0]    op1;
    logic [2:0]    op2;
  } elem_t;

  function automatic elem_t mk(input logic down, input logic [OW-1:0] nops,
                               input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c);
    elem_t e;
    e.down = down;
    e.nops = nops;
    e.op0  = a;
    e.op1  = b;
    e.op2  = c;
    return e;
  endfunction

  // Element table for every algorithm; unused op slots are don't-care.
  function automatic elem_t elem_desc(input logic [SW-1:0] alg, input logic [EW-1:0] idx);
    elem_t e;
    e = mk(1'b0, 2'd1, R0, R0, R0);
    case (alg)
      4'd1: case (idx)
        3'd0:    e = mk(1'b0, 2'd1, W0, R0, R0);
        3'd1:    e = mk(1'b0, 2'd2, R0, W1, R0);
        default: e = mk(1'b1, 2'd2, R1, W0, R0);
      endcase
      4'd2: case (idx)
        3'd0:    e = mk(1'b0, 2'd1, W0, R0, R0);
        3'd1:    e = mk(1'b0, 2'd2, R0, W1, R0);
        3'd2:    e = mk(1'b0, 2'd2, R1, W0, R0);
        3'd3:    e = mk(1'b1, 2'd2, R0, W1, R0);
        3'd4:    e = mk(1'b1, 2'd2, R1, W0, R0);
        default: e = mk(1'b0, 2'd1, R0, R0, R0);
      endcase
      4'd3: case (idx)
        3'd0:    e = mk(1'b0, 2'd1, W0, R0, R0);
        3'd1:    e = mk(1'b0, 2'd2, R0, W1, R0);
        3'd2:    e = mk(1'b1, 2'd2, R1, W0, R0);
        default: e = mk(1'b0, 2'd1, R0, R0, R0);
      endcase
      4'd4: case (idx)
        3'd0:    e = mk(1'b0, 2'd1, W0, R0, R0);
        3'd1:    e = mk(1'b0, 2'd3, R0, W1, R1);
        3'd2:    e = mk(1'b1, 2'd3, R1, W0, R0);
        default: e = mk(1'b0, 2'd1, R0, R0, R0);
      endcase
      4'd5: case (idx)
        3'd0:    e = mk(1'b0, 2'd1, WP, R0, R0);
        3'd1:    e = mk(1'b0, 2'd1, RP, R0, R0);
        3'd2:    e = mk(1'b0, 2'd1, WN, R0, R0);
        default: e = mk(1'b0, 2'd1, RN, R0, R0);
      endcase
      default: case (idx)
        3'd0:    e = mk(1'b0, 2'd1, W0, R0, R0);
        3'd1:    e = mk(1'b0, 2'd2, R0, W1, R0);
        default: e = mk(1'b0, 2'd1, R1, R0, R0);
      endcase
    endcase
    return e;
  endfunction

  function automatic logic [EW-1:0] n_elems(input logic [SW-1:0] alg);
    case (alg)
      4'd1:    return 3'd3;
      4'd2:    return 3'd6;
      4'd3:    return 3'd4;
      4'd4:    return 3'd4;
      4'd5:    return 3'd4;
      4'd6:    return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  // Background value for a data code; P alternates on the address LSB.
  function automatic logic [DW-1:0] bg(input logic [1:0] code, input logic odd);
    case (code)
      2'd0:    return 4'b0000;
      2'd1:    return 4'b1111;
      2'd2:    return odd ? 4'b1010 : 4'b0101;
      default: return odd ? 4'b0101 : 4'b1010;
    endcase
  endfunction

  function automatic logic [2:0] op_sel(input elem_t e, input logic [OW-1:0] i);
    case (i)
      2'd0:    return e.op0;
      2'd1:    return e.op1;
      default: return e.op2;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [EW-1:0] elem_q, elem_d;
  logic [OW-1:0] opi_q, opi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dat_out_q, dat_out_d;
  logic          w_en_q, w_en_d;
  logic          op_done_q, op_done_d;
  logic          fail_q, fail_d;

  elem_t         cur_e, nxt_e, ld_e;
  logic [2:0]    cur_op, ld_op;
  logic          load_op;
  logic          sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      elem_q    <= '0;
      opi_q     <= '0;
      addr_q    <= '0;
      dat_out_q <= '0;
      w_en_q    <= 1'b0;
      op_done_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      elem_q    <= elem_d;
      opi_q     <= opi_d;
      addr_q    <= addr_d;
      dat_out_q <= dat_out_d;
      w_en_q    <= w_en_d;
      op_done_q <= op_done_d;
      fail_q    <= fail_d;
    end
  end

  // Next state, counters and the registered outputs of the next op.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    elem_d    = elem_q;
    opi_d     = opi_q;
    addr_d    = addr_q;
    dat_out_d = '0;
    w_en_d    = 1'b0;
    op_done_d = 1'b0;
    fail_d    = fail_q;
    load_op   = 1'b0;
    sel_valid = (bus.select >= 4'd1) && (bus.select <= 4'd6);
    cur_e     = elem_desc(sel_q, elem_q);
    cur_op    = op_sel(cur_e, opi_q);
    nxt_e     = elem_desc(sel_q, elem_q + 3'd1);

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          sel_d   = bus.select;
          fail_d  = 1'b0;
          elem_d  = '0;
          opi_d   = '0;
          addr_d  = '0;
          state_d = S_RUN;
          load_op = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.select != sel_q) begin
          state_d = S_IDLE;
          elem_d  = '0;
          opi_d   = '0;
          addr_d  = '0;
        end else begin
          if (!cur_op[2] && (bus.dat_in != bg(cur_op[1:0], addr_q[0])))
            fail_d = 1'b1;
          if (opi_q != (cur_e.nops - 2'd1)) begin
            opi_d   = opi_q + 2'd1;
            load_op = 1'b1;
          end else begin
            opi_d = '0;
            if (addr_q != (cur_e.down ? 8'h00 : 8'hFF)) begin
              addr_d  = cur_e.down ? (addr_q - 8'd1) : (addr_q + 8'd1);
              load_op = 1'b1;
            end else if ((elem_q + 3'd1) == n_elems(sel_q)) begin
              state_d   = S_DONE;
              op_done_d = 1'b1;
              elem_d    = '0;
              addr_d    = '0;
            end else begin
              elem_d  = elem_q + 3'd1;
              addr_d  = nxt_e.down ? 8'hFF : 8'h00;
              load_op = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (bus.select != sel_q) state_d = S_IDLE;
        else                     op_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ld_e  = elem_desc(sel_d, elem_d);
    ld_op = op_sel(ld_e, opi_d);
    if (load_op) begin
      w_en_d    = ld_op[2];
      dat_out_d = ld_op[2] ? bg(ld_op[1:0], addr_d[0]) : 4'b0000;
    end
  end

  assign bus.addr_out = addr_q;
  assign bus.dat_out  = dat_out_q;
  assign bus.w_en     = w_en_q;
  assign bus.op_done  = op_done_q;
  assign bus.fail     = fail_q;
endmodule

// File: tb/tb_bist_engine.sv
// Bench for bist_engine: SRAM model with injectable faults, run-length and
// fail scoreboard checked by a monitor on each op_done rise.
module tb_bist_engine;
  localparam int unsigned N_WORDS = 256;

  typedef struct {
    int unsigned start;
    int unsigned len;
    logic        fail;
    int unsigned sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  bist_engine_if bus();

  bist_engine u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: stuck-at-1 on bit 2 of 0x3C, and an idempotent coupling
  // fault where a rising write to 0x10 forces 0x11 to zero.
  logic [3:0] mem [N_WORDS];
  logic sa_en = 1'b0;
  logic cf_en = 1'b0;

  assign bus.dat_in = mem[bus.addr_out] |
                      ((sa_en && bus.addr_out == 8'h3C) ? 4'b0100 : 4'b0000);

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) mem[i] <= 4'b0000;
    end else if (bus.w_en) begin
      if (cf_en && bus.addr_out == 8'h10 && ((~mem[8'h10] & bus.dat_out) != 4'b0000))
        mem[8'h11] <= 4'b0000;
      mem[bus.addr_out] <= bus.dat_out;
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each op_done rise retires the oldest expected run.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.op_done && !done_prev) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_op_done: op_done rose at cycle %0d with no run expected", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("run_len sel=%0d", e.sel), cyc - e.start, e.len);
        chk($sformatf("run_fail sel=%0d", e.sel), 32'(bus.fail), 32'(e.fail));
      end
    end
    done_prev = bus.op_done;
  end

  task automatic start(input logic [3:0] sel, input int unsigned lag, input bit push,
                       input int unsigned len, input logic f, output int unsigned t0);
    exp_t e;
    bus.select = sel;
    t0 = cyc + lag;
    if (push) begin
      e.start = t0;
      e.len   = len;
      e.fail  = f;
      e.sel   = 32'(sel);
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done(input int unsigned limit, input string name);
    int unsigned n = 0;
    while (!bus.op_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.op_done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: op_done still 0 after %0d cycles", name, limit);
    end
  endtask

  task automatic go_idle();
    bus.select = 4'd0;
    repeat (2) @(negedge clk);
  endtask

  // kind: 0 = all zeros, 1 = ~P checkerboard, 2 = all ones
  task automatic chk_mem(input string name, input int unsigned kind);
    int unsigned nmis = 0;
    logic [3:0] exp;
    for (int i = 0; i < N_WORDS; i++) begin
      case (kind)
        0:       exp = 4'b0000;
        1:       exp = i[0] ? 4'b0101 : 4'b1010;
        default: exp = 4'b1111;
      endcase
      if (mem[i] !== exp) nmis++;
    end
    chk(name, nmis, 0);
  endtask

  task automatic chk_first_op(input string name, input logic [3:0] d);
    chk(name, {bus.addr_out, bus.w_en, bus.dat_out}, {8'h00, 1'b1, d});
  endtask

  int unsigned run_len  [6] = '{1280, 2560, 1536, 2048, 1024, 1024};
  int unsigned mem_kind [6] = '{0, 0, 0, 0, 1, 2};

  initial begin
    int unsigned t0, t1;
    rst_n      = 1'b0;
    bus.select = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_addr", 32'(bus.addr_out), 0);
    chk("reset_w_en", 32'(bus.w_en), 0);
    chk("reset_dat_out", 32'(bus.dat_out), 0);
    chk("reset_op_done", 32'(bus.op_done), 0);
    chk("reset_fail", 32'(bus.fail), 0);
    rst_n = 1'b1;

    // Idle codes produce no activity
    bus.select = 4'd7;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("idle_sel7", {bus.op_done, bus.w_en, bus.addr_out}, 0);
    end
    bus.select = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_sel0", {bus.op_done, bus.w_en, bus.addr_out}, 0);
    end

    // Fault-free sweep, select stepped on each op_done
    start(4'd1, 1, 1'b1, run_len[0], 1'b0, t0);
    for (int s = 1; s <= 6; s++) begin
      wait_cyc(t0);
      chk_first_op($sformatf("first_op sel=%0d", s), (s == 5) ? 4'b0101 : 4'b0000);
      @(negedge clk);
      wait_done(run_len[s-1] + 16, "sweep");
      chk_mem($sformatf("mem_after sel=%0d", s), mem_kind[s-1]);
      if (s < 6) start(4'(s + 1), 2, 1'b1, run_len[s], 1'b0, t0);
    end

    // Asynchronous reset in the middle of a failing March C- run
    go_idle();
    sa_en = 1'b1;
    start(4'd2, 1, 1'b0, 0, 1'b0, t0);
    wait_cyc(t0 + 500);
    chk("fail_before_reset", 32'(bus.fail), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_addr", 32'(bus.addr_out), 0);
    chk("midrun_reset_w_en", 32'(bus.w_en), 0);
    chk("midrun_reset_op_done", 32'(bus.op_done), 0);
    chk("midrun_reset_fail", 32'(bus.fail), 0);
    sa_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start(4'd2, 1, 1'b1, 2560, 1'b0, t0);
    wait_cyc(t0);
    chk_first_op("restart_first_op", 4'b0000);
    wait_done(2600, "restart");

    // Stuck-at-1 on 0x3C bit 2 under MATS+
    go_idle();
    sa_en = 1'b1;
    start(4'd1, 1, 1'b1, 1280, 1'b1, t0);
    wait_cyc(t0);
    while (!bus.fail && cyc < t0 + 1300) @(negedge clk);
    chk("sa_fail_cycle", cyc - t0, 256 + 2 * 60 + 1);
    wait_done(1300, "stuck_at");
    sa_en = 1'b0;

    // Coupling fault 0x10 -> 0x11: March C- catches it, MATS does not
    go_idle();
    cf_en = 1'b1;
    start(4'd2, 1, 1'b1, 2560, 1'b1, t0);
    @(negedge clk);
    wait_done(2600, "coupling_c");
    go_idle();
    start(4'd6, 1, 1'b1, 1024, 1'b0, t0);
    @(negedge clk);
    wait_done(1100, "coupling_mats");
    cf_en = 1'b0;

    // Abort March X at cycle 500 by switching to March Y
    go_idle();
    start(4'd3, 1, 1'b0, 0, 1'b0, t0);
    wait_cyc(t0 + 500);
    start(4'd4, 2, 1'b1, 2048, 1'b0, t1);
    wait_cyc(t1);
    chk_first_op("abort_first_op", 4'b0000);
    @(negedge clk);
    wait_done(2100, "abort");

    go_idle();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
